// File: rtl/moore_seq_detector_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared types and helpers for the Moore serial-pattern detector.
//   state_t  : detector FSM state encoding
//   hit_cmp  : masked window/pattern compare. The unmasked build passes an
//              all-ones mask. Operands are zero-extended to CMP_MAX_W, so
//              N must not exceed CMP_MAX_W.
// Optional feature macro: SEQDET_MASK_EN (see moore_seq_detector.sv)
// ---------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ARMED = 2'd1,
        S_HIT   = 2'd2
    } state_t;

    localparam int unsigned CMP_MAX_W = 64;

    function automatic logic hit_cmp(
        input logic [CMP_MAX_W-1:0] win,
        input logic [CMP_MAX_W-1:0] pat,
        input logic [CMP_MAX_W-1:0] mask
    );
        return ((win ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// ---------------------------------------------------------------------------
// moore_seq_detector_if
// Serial-stream, configuration and result signals of the detector.
//   din_valid, din         : serial bit with per-beat qualifier
//   pattern, overlap_en    : runtime target pattern and overlap mode
//   pattern_mask           : per-bit compare enable (only with SEQDET_MASK_EN)
//   cnt_clr                : synchronous clear of match_cnt
//   dout, match_cnt        : match pulse and saturating match count
// Modports: master (stream source / config owner), slave (detector).
// Optional feature macro: SEQDET_MASK_EN
// ---------------------------------------------------------------------------
interface moore_seq_detector_if #(
    parameter int N     = 3,
    parameter int CNT_W = 8
);
    logic             din_valid;
    logic             din;
    logic [N-1:0]     pattern;
`ifdef SEQDET_MASK_EN
    logic [N-1:0]     pattern_mask;
`endif
    logic             overlap_en;
    logic             cnt_clr;
    logic             dout;
    logic [CNT_W-1:0] match_cnt;

`ifdef SEQDET_MASK_EN
    modport master (
        output din_valid, din, pattern, pattern_mask, overlap_en, cnt_clr,
        input  dout, match_cnt
    );
    modport slave (
        input  din_valid, din, pattern, pattern_mask, overlap_en, cnt_clr,
        output dout, match_cnt
    );
`else
    modport master (
        output din_valid, din, pattern, overlap_en, cnt_clr,
        input  dout, match_cnt
    );
    modport slave (
        input  din_valid, din, pattern, overlap_en, cnt_clr,
        output dout, match_cnt
    );
`endif

endinterface

// File: rtl/moore_seq_detector_sat_cnt.sv
// ---------------------------------------------------------------------------
// seq_det_sat_cnt
// Saturating up-counter with clear taking priority over increment.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear (wins over inc)
//   cnt        : current count, holds at all-ones
// ---------------------------------------------------------------------------
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// ---------------------------------------------------------------------------
// moore_seq_detector
// Parametrised Moore serial-pattern detector with overlap/non-overlap mode,
// one-cycle match pulse and saturating match counter.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : moore_seq_detector_if.slave (stream, config, results)
// Optional feature macro: SEQDET_MASK_EN adds bus.pattern_mask; mask bits at
// 0 are don't-care in the compare. Without it the full N-bit pattern is used.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FILL  | fewer than N fresh bits in the window, no match possible
// S_ARMED | window full, last valid beat was not a match
// S_HIT   | last valid beat completed a match, dout high
// ---------------------------------------------------------------------------
module moore_seq_detector
    import seq_det_pkg::*;
#(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    moore_seq_detector_if.slave  bus
);

    localparam int FILL_W = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

    logic [N-1:0]      window;
    logic [N-1:0]      win_nxt;
    logic [N-1:0]      mask;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic              hit;
    state_t            state;
    state_t            state_nxt;

    assign win_nxt  = {window[N-2:0], bus.din};
    assign fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;

`ifdef SEQDET_MASK_EN
    assign mask = bus.pattern_mask;
`else
    assign mask = '1;
`endif

    assign hit = hit_cmp(CMP_MAX_W'(win_nxt), CMP_MAX_W'(bus.pattern), CMP_MAX_W'(mask))
                 && (fill_nxt == FILL_FULL);

    // Non-overlap restarts fill so the next match needs N entirely new bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
            fill   <= '0;
        end else if (bus.din_valid) begin
            window <= win_nxt;
            fill   <= (hit && !bus.overlap_en) ? '0 : fill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.din_valid) begin
            if (hit) begin
                state_nxt = S_HIT;
            end else if (fill_nxt == FILL_FULL) begin
                state_nxt = S_ARMED;
            end else begin
                state_nxt = S_FILL;
            end
        end else if (state == S_HIT) begin
            // A stall ends the pulse; fill tells us whether the window is
            // still usable (overlap) or was restarted (non-overlap).
            state_nxt = (fill == FILL_FULL) ? S_ARMED : S_FILL;
        end
    end

    always_comb begin
        bus.dout = (state == S_HIT);
    end

    // Counts on the same edge the FSM enters S_HIT, so match_cnt and dout
    // change together.
    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.din_valid && hit),
        .clr   (bus.cnt_clr),
        .cnt   (bus.match_cnt)
    );

endmodule

// File: tb/tb_moore_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_moore_seq_detector
// Directed-vector bench for moore_seq_detector. Two instances share the
// same stimulus: dut_a (N=3, CNT_W=8) and dut_b (N=3, CNT_W=2) for the
// saturation case. Mask cases are built only with SEQDET_MASK_EN.
// ---------------------------------------------------------------------------
module tb_moore_seq_detector;
    import seq_det_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    moore_seq_detector_if #(.N(3), .CNT_W(8)) if_a ();
    moore_seq_detector_if #(.N(3), .CNT_W(2)) if_b ();

    moore_seq_detector #(.N(3), .CNT_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    moore_seq_detector #(.N(3), .CNT_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [2:0] pat, input logic ov, input logic [2:0] msk);
        if_a.pattern    = pat;
        if_b.pattern    = pat;
        if_a.overlap_en = ov;
        if_b.overlap_en = ov;
`ifdef SEQDET_MASK_EN
        if_a.pattern_mask = msk;
        if_b.pattern_mask = msk;
`else
        if (msk != 3'b111) $display("note: mask ignored in unmasked build");
`endif
    endtask

    // Drive one cycle at the falling edge, return 1 time unit after the
    // following rising edge so outputs can be sampled.
    task automatic drive(input logic v, input logic d, input logic clr);
        @(negedge clk);
        if_a.din_valid = v;
        if_b.din_valid = v;
        if_a.din       = d;
        if_b.din       = d;
        if_a.cnt_clr   = clr;
        if_b.cnt_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        if_a.din_valid = 1'b0;
        if_b.din_valid = 1'b0;
        if_a.cnt_clr   = 1'b0;
        if_b.cnt_clr   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] s5;
        logic [7:0] s8;
        logic [8:0] s9;
        logic [4:0] e5;
        logic [7:0] e8;
        logic [8:0] e9;
        int         c9 [9];

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        if_a.din = 1'b0;
        if_b.din = 1'b0;
        set_cfg(3'b101, 1'b1, 3'b111);
        do_reset();

        chk("reset_dout",  int'(if_a.dout), 0);
        chk("reset_cnt",   int'(if_a.match_cnt), 0);
        chk("reset_state", int'(dut_a.state), int'(S_FILL));
        chk("reset_fill",  int'(dut_a.fill), 0);

        // Overlap, stream 1,0,1,0,1 (first bit at index 4).
        s5 = 5'b10101;
        e5 = 5'b00101;
        for (int i = 4; i >= 0; i--) begin
            drive(1'b1, s5[i], 1'b0);
            chk($sformatf("ovl_dout_b%0d", 5 - i), int'(if_a.dout), int'(e5[i]));
        end
        chk("ovl_cnt", int'(if_a.match_cnt), 2);

        // Non-overlap, stream 1,0,1,0,1,1,0,1: pulses after bits 3 and 8.
        set_cfg(3'b101, 1'b0, 3'b111);
        do_reset();
        s8 = 8'b10101101;
        e8 = 8'b00100001;
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, s8[i], 1'b0);
            chk($sformatf("novl_dout_b%0d", 8 - i), int'(if_a.dout), int'(e8[i]));
        end
        chk("novl_cnt", int'(if_a.match_cnt), 2);

        // Stall: 1,0, four idle cycles, then 1; then one idle after the hit.
        set_cfg(3'b101, 1'b1, 3'b111);
        do_reset();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            chk("stall_dout",  int'(if_a.dout), 0);
            chk("stall_state", int'(dut_a.state), int'(S_FILL));
            chk("stall_fill",  int'(dut_a.fill), 2);
        end
        drive(1'b1, 1'b1, 1'b0);
        chk("stall_hit_dout",  int'(if_a.dout), 1);
        chk("stall_hit_state", int'(dut_a.state), int'(S_HIT));
        drive(1'b0, 1'b0, 1'b0);
        chk("post_hit_stall_dout",  int'(if_a.dout), 0);
        chk("post_hit_stall_state", int'(dut_a.state), int'(S_ARMED));
        chk("post_hit_stall_cnt",   int'(if_a.match_cnt), 1);

        // Reset mid-stream discards the partial 1,0.
        do_reset();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        do_reset();
        drive(1'b1, 1'b1, 1'b0);
        chk("midrst_dout",  int'(if_a.dout), 0);
        chk("midrst_fill",  int'(dut_a.fill), 1);
        chk("midrst_state", int'(dut_a.state), int'(S_FILL));
        chk("midrst_cnt",   int'(if_a.match_cnt), 0);

        // Back-to-back hits: pattern 111, stream 1,1,1,1.
        set_cfg(3'b111, 1'b1, 3'b111);
        do_reset();
        e5 = 5'b00110;
        for (int i = 4; i >= 1; i--) begin
            drive(1'b1, 1'b1, 1'b0);
            chk($sformatf("b2b_dout_b%0d", 5 - i), int'(if_a.dout), int'(e5[i]));
        end
        chk("b2b_cnt", int'(if_a.match_cnt), 2);

        // Saturation on 2-bit counter: 1,0,1,0,1,0,1,0,1 -> counts 1,2,3,3.
        set_cfg(3'b101, 1'b1, 3'b111);
        do_reset();
        s9 = 9'b101010101;
        e9 = 9'b001010101;
        c9 = '{0, 0, 1, 1, 2, 2, 3, 3, 3};
        for (int i = 8; i >= 0; i--) begin
            drive(1'b1, s9[i], 1'b0);
            chk($sformatf("sat_dout_b%0d", 9 - i), int'(if_b.dout), int'(e9[i]));
            chk($sformatf("sat_cnt_b%0d", 9 - i), int'(if_b.match_cnt), c9[8 - i]);
        end

        // Same stream with cnt_clr on the 4th hit: clear wins, pulse remains.
        do_reset();
        for (int i = 8; i >= 0; i--) begin
            drive(1'b1, s9[i], (i == 0));
        end
        chk("clr_hit_dout",  int'(if_b.dout), 1);
        chk("clr_hit_cnt_b", int'(if_b.match_cnt), 0);
        chk("clr_hit_cnt_a", int'(if_a.match_cnt), 0);
        drive(1'b0, 1'b0, 1'b0);
        chk("clr_after_cnt", int'(if_b.match_cnt), 0);

`ifdef SEQDET_MASK_EN
        // Middle bit don't-care: 1,1,1 matches 1x1.
        set_cfg(3'b101, 1'b1, 3'b101);
        do_reset();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        chk("mask_101_dout", int'(if_a.dout), 1);

        // All-zero mask: dout on every valid beat once fill reaches N.
        set_cfg(3'b101, 1'b1, 3'b000);
        do_reset();
        e5 = 5'b00111;
        for (int i = 4; i >= 0; i--) begin
            drive(1'b1, 1'b0, 1'b0);
            chk($sformatf("mask_0_dout_b%0d", 5 - i), int'(if_a.dout), int'(e5[i]));
        end
        chk("mask_0_cnt", int'(if_a.match_cnt), 3);
`endif

        drive(1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
